// File: rtl/cpu_ext_if.sv
// cpu_ext_if: memory bus and in/out channel bundle for cpu_ext.
// master = CPU side, slave = memory / top-level I/O side.
interface cpu_ext_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
) ();
    logic [DATA_WIDTH-1:0] mem_in;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic [DATA_WIDTH-1:0] in;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] out;
    logic                  out_valid;

    modport master (
        input  mem_in, in, in_valid,
        output mem_we, mem_addr, mem_data, out, out_valid
    );

    modport slave (
        output mem_in, in, in_valid,
        input  mem_we, mem_addr, mem_data, out, out_valid
    );
endinterface

// File: rtl/cpu_ext.sv
// cpu_ext: multi-cycle memory-to-memory CPU (MOV IN OUT ADD SUB MUL DIV STOP).
// Define CPU_DIV_EN to build the restoring divider; otherwise DIV is a NOP.
module cpu_ext #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16,
    parameter int PC_START   = 8,
    parameter int SP_START   = (1 << ADDR_WIDTH) - 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cpu_ext_if.master             bus,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] sp,
    output logic                  halted
);
    localparam int AW = ADDR_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam logic [AW-1:0] PC_RST = AW'(PC_START);
    localparam logic [AW-1:0] SP_RST = AW'(SP_START);

`ifdef CPU_DIV_EN
    localparam logic DIV_ON = 1'b1;
`else
    localparam logic DIV_ON = 1'b0;
`endif

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_FWAIT  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_OPND   = 4'd3;
    localparam logic [3:0] S_OWAIT  = 4'd4;
    localparam logic [3:0] S_OCAP   = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_INW    = 4'd7;
    localparam logic [3:0] S_WB     = 4'd8;
    localparam logic [3:0] S_WPW    = 4'd9;
    localparam logic [3:0] S_WPC    = 4'd10;
    localparam logic [3:0] S_STOPO  = 4'd11;
    localparam logic [3:0] S_STOPG  = 4'd12;
    localparam logic [3:0] S_HALT   = 4'd13;
    localparam logic [3:0] S_DIV    = 4'd14;

    localparam logic [3:0] OP_MOV  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_MUL  = 4'h3;
    localparam logic [3:0] OP_DIV  = 4'h4;
    localparam logic [3:0] OP_IN   = 4'h7;
    localparam logic [3:0] OP_OUT  = 4'h8;
    localparam logic [3:0] OP_STOP = 4'hF;

    // Operand slots to read: bit0=a1, bit1=a2, bit2=a3.
    function automatic logic [2:0] need_of(input logic [15:0] w);
        logic [2:0] m;
        m = 3'b000;
        unique case (1'b1)
            w[15:12] == OP_MOV:                 m = 3'b010;
            w[15:12] == OP_ADD,
            w[15:12] == OP_SUB,
            w[15:12] == OP_MUL:                 m = 3'b110;
            (w[15:12] == OP_DIV) && DIV_ON:     m = 3'b110;
            w[15:12] == OP_OUT:                 m = 3'b001;
            w[15:12] == OP_STOP:
                m = {w[3:0] != 4'd0, w[7:4] != 4'd0, w[11:8] != 4'd0};
            default:                            m = 3'b000;
        endcase
        return m;
    endfunction

    function automatic logic [AW-1:0] dir(input logic [3:0] n);
        return {{(AW-3){1'b0}}, n[2:0]};
    endfunction

    logic [3:0]    state;
    logic [15:0]   ir;
    logic [2:0]    need;
    logic [2:0]    omask;
    logic          ind;
    logic [DW-1:0] opv [3];
    logic [DW-1:0] res;

    logic [3:0] op;
    logic [3:0] nib [3];
    logic [1:0] oi;
    logic [1:0] ki;
    logic is_mov, is_add, is_sub, is_mul, is_div;
    logic is_in, is_out, is_stop;

    // Field split, next-operand pick and opcode flags.
    always_comb begin
        op     = ir[15:12];
        nib[0] = ir[11:8];
        nib[1] = ir[7:4];
        nib[2] = ir[3:0];
        oi = 2'd2;
        if (need[1]) oi = 2'd1;
        if (need[0]) oi = 2'd0;
        ki = 2'd2;
        if (omask[1]) ki = 2'd1;
        if (omask[0]) ki = 2'd0;
        is_mov  = (op == OP_MOV);
        is_add  = (op == OP_ADD);
        is_sub  = (op == OP_SUB);
        is_mul  = (op == OP_MUL);
        is_div  = DIV_ON && (op == OP_DIV);
        is_in   = (op == OP_IN);
        is_out  = (op == OP_OUT);
        is_stop = (op == OP_STOP);
    end

`ifdef CPU_DIV_EN
    localparam int DCW = $clog2(DATA_WIDTH + 1);
    logic [DW-1:0]  dq;
    logic [DW-1:0]  drem;
    logic [DCW-1:0] dcnt;
    logic [DW:0]    dsh;
    logic [DW:0]    ddiff;
    logic           div_done;

    // Trial subtraction for the restoring divider.
    always_comb begin
        dsh      = {drem, dq[DW-1]};
        ddiff    = dsh - {1'b0, opv[2]};
        div_done = (dcnt == DCW'(DW));
    end

    // One quotient bit per cycle; loaded on every EXEC entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dq   <= '0;
            drem <= '0;
            dcnt <= '0;
        end else if (state == S_EXEC) begin
            dq   <= opv[1];
            drem <= '0;
            dcnt <= '0;
        end else if (state == S_DIV && !div_done) begin
            dq   <= {dq[DW-2:0], ~ddiff[DW]};
            drem <= ddiff[DW] ? dsh[DW-1:0] : ddiff[DW-1:0];
            dcnt <= dcnt + 1'b1;
        end
    end
`endif

    // Main sequencer: fetch, operand reads, execute, write-back, halt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_FETCH;
            pc            <= PC_RST;
            sp            <= SP_RST;
            halted        <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_data  <= '0;
            bus.out       <= '0;
            bus.out_valid <= 1'b0;
            ir            <= '0;
            need          <= '0;
            omask         <= '0;
            ind           <= 1'b0;
            res           <= '0;
            for (int i = 0; i < 3; i++) opv[i] <= '0;
        end else begin
            bus.mem_we    <= 1'b0;
            bus.out_valid <= 1'b0;
            case (state)
                S_FETCH: begin
                    bus.mem_addr <= pc;
                    state        <= S_FWAIT;
                end
                S_FWAIT: state <= S_DECODE;
                S_DECODE: begin
                    ir    <= bus.mem_in[15:0];
                    pc    <= pc + 1'b1;
                    need  <= need_of(bus.mem_in[15:0]);
                    omask <= need_of(bus.mem_in[15:0]);
                    state <= S_OPND;
                end
                S_OPND: begin
                    if (need == 3'b000) begin
                        state <= S_EXEC;
                    end else begin
                        bus.mem_addr <= dir(nib[oi]);
                        ind          <= nib[oi][3];
                        state        <= S_OWAIT;
                    end
                end
                S_OWAIT: state <= S_OCAP;
                S_OCAP: begin
                    if (ind) begin
                        bus.mem_addr <= bus.mem_in[AW-1:0];
                        ind          <= 1'b0;
                        state        <= S_OWAIT;
                    end else begin
                        opv[oi]  <= bus.mem_in;
                        need[oi] <= 1'b0;
                        state    <= S_OPND;
                    end
                end
                S_EXEC: begin
                    unique case (1'b1)
                        is_mov: begin
                            res   <= opv[1];
                            state <= S_WB;
                        end
                        is_add: begin
                            res   <= opv[1] + opv[2];
                            state <= S_WB;
                        end
                        is_sub: begin
                            res   <= opv[1] - opv[2];
                            state <= S_WB;
                        end
                        is_mul: begin
                            res   <= opv[1] * opv[2];
                            state <= S_WB;
                        end
                        is_div:  state <= S_DIV;
                        is_in:   state <= S_INW;
                        is_out: begin
                            bus.out       <= opv[0];
                            bus.out_valid <= 1'b1;
                            state         <= S_FETCH;
                        end
                        is_stop: state <= S_STOPO;
                        default: state <= S_FETCH;
                    endcase
                end
                S_INW: begin
                    if (bus.in_valid) begin
                        res   <= bus.in;
                        state <= S_WB;
                    end
                end
                S_WB: begin
                    bus.mem_addr <= dir(nib[0]);
                    if (nib[0][3]) begin
                        state <= S_WPW;
                    end else begin
                        bus.mem_we   <= 1'b1;
                        bus.mem_data <= res;
                        state        <= S_FETCH;
                    end
                end
                S_WPW: state <= S_WPC;
                S_WPC: begin
                    bus.mem_we   <= 1'b1;
                    bus.mem_addr <= bus.mem_in[AW-1:0];
                    bus.mem_data <= res;
                    state        <= S_FETCH;
                end
                S_STOPO: begin
                    if (omask == 3'b000) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else begin
                        bus.out       <= opv[ki];
                        bus.out_valid <= 1'b1;
                        omask[ki]     <= 1'b0;
                        state         <= S_STOPG;
                    end
                end
                S_STOPG: state <= S_STOPO;
                S_HALT:  state <= S_HALT;
`ifdef CPU_DIV_EN
                S_DIV: begin
                    if (div_done) begin
                        res   <= (opv[2] == '0) ? '0 : dq;
                        state <= S_WB;
                    end
                end
`endif
                default: state <= S_FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_ext.sv
// tb_cpu_ext: directed programs checked against an instruction-level model.
// Writes and output pulses are compared every cycle; final memory after halt.
module tb_cpu_ext;
    typedef struct packed {
        logic [5:0]  addr;
        logic [15:0] data;
    } wr_t;

`ifdef CPU_DIV_EN
    localparam logic [15:0] DIV_EXP  = 16'h0003;
    localparam logic [15:0] DIV0_EXP = 16'h0000;
`else
    localparam logic [15:0] DIV_EXP  = 16'h1234;
    localparam logic [15:0] DIV0_EXP = 16'h1234;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [5:0] pc;
    logic [5:0] sp;
    logic       halted;
    logic       ld = 1'b0;

    logic [15:0] img [64];
    logic [15:0] mem [64];
    logic [15:0] mm  [64];
    int          mpc;
    wr_t         wq [$];
    logic [15:0] oq [$];
    logic [15:0] seen [$];
    logic        prev_ov;
    int          checks = 0;
    int          failures = 0;

    cpu_ext_if #(.ADDR_WIDTH(6), .DATA_WIDTH(16)) bus ();

    cpu_ext dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .pc     (pc),
        .sp     (sp),
        .halted (halted)
    );

    always #5 clk = ~clk;

    // Synchronous single-port memory with a bulk-load path.
    always @(posedge clk) begin
        if (ld) begin
            for (int i = 0; i < 64; i++) mem[i] <= img[i];
        end else begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_data;
            bus.mem_in <= mem[bus.mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] ea(input logic [3:0] n);
        return n[3] ? mm[n[2:0]][5:0] : {3'b000, n[2:0]};
    endfunction

    task automatic put(input logic [5:0] a, input logic [15:0] v);
        wq.push_back('{addr: a, data: v});
        mm[a] = v;
    endtask

    // Instruction-level reference: expected writes, outputs, final pc/memory.
    task automatic model(input logic [15:0] inval);
        logic [15:0] w, v1, v2, v3;
        logic [3:0]  op, n1, n2, n3;
        logic [5:0]  d;
        for (int i = 0; i < 64; i++) mm[i] = img[i];
        wq.delete();
        oq.delete();
        mpc = 8;
        for (int s = 0; s < 400; s++) begin
            w   = mm[mpc];
            mpc = (mpc + 1) % 64;
            op = w[15:12]; n1 = w[11:8]; n2 = w[7:4]; n3 = w[3:0];
            v1 = mm[ea(n1)]; v2 = mm[ea(n2)]; v3 = mm[ea(n3)];
            d  = ea(n1);
            if (op == 4'hF) begin
                if (n1 != 4'd0) oq.push_back(v1);
                if (n2 != 4'd0) oq.push_back(v2);
                if (n3 != 4'd0) oq.push_back(v3);
                break;
            end
            case (op)
                4'h0: put(d, v2);
                4'h1: put(d, v2 + v3);
                4'h2: put(d, v2 - v3);
                4'h3: put(d, v2 * v3);
`ifdef CPU_DIV_EN
                4'h4: put(d, (v3 == 16'd0) ? 16'd0 : v2 / v3);
`endif
                4'h7: put(d, inval);
                4'h8: oq.push_back(v1);
                default: ;
            endcase
        end
    endtask

    task automatic clear_img();
        for (int i = 0; i < 64; i++) img[i] = 16'h0000;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        ld    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ld = 1'b0;
        seen.delete();
        prev_ov = 1'b0;
        chk("rst_pc", pc, 8);
        chk("rst_sp", sp, 63);
        chk("rst_out", bus.out, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_data", bus.mem_data, 0);
        chk("rst_halted", halted, 0);
    endtask

    // Per-cycle comparison of bus activity against the model queues.
    task automatic cycle_check(input bit stalling);
        wr_t e;
        if (stalling) chk("stall_we", bus.mem_we, 0);
        if (bus.mem_we) begin
            if (wq.size() == 0) begin
                chk("extra_write", bus.mem_we, 0);
            end else begin
                e = wq.pop_front();
                chk("wr_addr", bus.mem_addr, e.addr);
                chk("wr_data", bus.mem_data, e.data);
            end
        end
        if (bus.out_valid) begin
            chk("out_pulse", prev_ov, 0);
            seen.push_back(bus.out);
            if (oq.size() == 0) chk("extra_out", bus.out_valid, 0);
            else chk("out_data", bus.out, oq.pop_front());
        end
        prev_ov = bus.out_valid;
    endtask

    task automatic run(input int budget, input int stall,
                       input bit abort_we, output bit hit);
        hit = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            cycle_check(c < stall);
            bus.in_valid = (c + 1 >= stall);
            if (abort_we && bus.mem_we) begin
                hit = 1'b1;
                break;
            end
            if (!abort_we && halted) begin
                hit = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_test(input logic [15:0] inval, input int stall);
        bit hit;
        apply_reset();
        model(inval);
        bus.in       = inval;
        bus.in_valid = (stall == 0);
        rst_n = 1'b1;
        run(3000, stall, 1'b0, hit);
        chk("halt_reached", hit, 1);
        chk("writes_left", wq.size(), 0);
        chk("outs_left", oq.size(), 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("halt_pc", pc, mpc);
            chk("halt_flag", halted, 1);
            chk("halt_we", bus.mem_we, 0);
            chk("halt_ov", bus.out_valid, 0);
        end
        chk("halt_sp", sp, 63);
        for (int i = 0; i < 64; i++) chk("mem_image", mem[i], mm[i]);
    endtask

    initial begin
        bit hit;
        bus.in       = 16'h0000;
        bus.in_valid = 1'b0;
        prev_ov      = 1'b0;

        clear_img();
        img[8] = 16'h7100; img[9] = 16'hF000;
        do_test(16'h0005, 10);
        chk("in_mem1", mem[1], 16'h0005);
        chk("in_pc", pc, 10);

        clear_img();
        img[1] = 16'h0003; img[2] = 16'h0004; img[3] = 16'h0020;
        img[8] = 16'h1B12; img[9] = 16'hF000;
        do_test(16'h0000, 0);
        chk("addi_mem20", mem[32], 16'h0007);
        chk("addi_mem3", mem[3], 16'h0020);

        clear_img();
        img[1] = 16'h0002; img[2] = 16'h0005;
        img[8] = 16'h2312; img[9] = 16'hF000;
        do_test(16'h0000, 0);
        chk("sub_wrap", mem[3], 16'hFFFD);

        clear_img();
        img[1] = 16'h0100; img[2] = 16'h0100; img[3] = 16'h5555;
        img[8] = 16'h3312; img[9] = 16'hF000;
        do_test(16'h0000, 0);
        chk("mul_wrap", mem[3], 16'h0000);

        clear_img();
        img[1] = 16'h0007; img[2] = 16'h0002; img[3] = 16'h1234;
        img[8] = 16'h4312; img[9] = 16'hF000;
        do_test(16'h0000, 0);
        chk("div_res", mem[3], DIV_EXP);
        chk("div_pc", pc, 10);

        clear_img();
        img[1] = 16'h0007; img[2] = 16'h0000; img[3] = 16'h1234;
        img[8] = 16'h4312; img[9] = 16'hF000;
        do_test(16'h0000, 0);
        chk("div0_res", mem[3], DIV0_EXP);

        clear_img();
        img[1] = 16'h00AA; img[2] = 16'h00BB;
        img[8] = 16'hF120;
        do_test(16'h0000, 0);
        chk("stop_count", seen.size(), 2);
        if (seen.size() >= 2) begin
            chk("stop_out0", seen[0], 16'h00AA);
            chk("stop_out1", seen[1], 16'h00BB);
        end
        chk("stop_pc", pc, 9);

        clear_img();
        img[1] = 16'h0006; img[6] = 16'h0021;
        img[8]  = 16'h0510; img[9]  = 16'h8500; img[10] = 16'h5000;
        img[11] = 16'h1999; img[12] = 16'hF5D0;
        do_test(16'h0000, 0);
        chk("mix_mem5", mem[5], 16'h0006);
        chk("mix_mem6", mem[6], 16'h0042);
        chk("mix_out_last", bus.out, 16'h0042);
        chk("mix_out_count", seen.size(), 3);

        clear_img();
        for (int i = 1; i < 64; i++) img[i] = 16'h5000;
        img[0] = 16'hF000;
        do_test(16'h0000, 0);
        chk("wrap_pc", pc, 1);

        clear_img();
        img[1] = 16'h0003; img[2] = 16'h0004; img[3] = 16'h0099;
        img[8] = 16'h1312; img[9] = 16'hF000;
        apply_reset();
        model(16'h0000);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        run(3000, 0, 1'b1, hit);
        chk("abort_reached", hit, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_we", bus.mem_we, 0);
        chk("abort_pc", pc, 8);
        chk("abort_halted", halted, 0);
        chk("abort_out", bus.out, 0);
        @(posedge clk);
        @(negedge clk);
        chk("abort_mem3", mem[3], 16'h0099);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
